// File: rtl/fifo_nword_fwft.sv
// First-word-fall-through FIFO: a registered head word in front of a (words-1)-entry
// circular buffer, with fill level, almost flags, synchronous flush and sticky error flags.
module fifo_nword_fwft #(
    parameter int bits     = 8,
    parameter int words    = 4,
    parameter int af_level = 3,
    parameter int ae_level = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       shift_in,
    input  logic                       shift_out,
    input  logic [bits-1:0]            data_in,
    output logic [bits-1:0]            data_out,
    output logic                       fifo_not_empty,
    output logic                       fifo_full,
    output logic                       fifo_almost_full,
    output logic                       fifo_almost_empty,
    output logic [$clog2(words+1)-1:0] level,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int DEPTH = words - 1;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = $clog2(words + 1);

    logic [bits-1:0] mem_q [DEPTH];
    logic [bits-1:0] head_q, head_d;
    logic            head_vld_q, head_vld_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            af_q, af_d, ae_q, ae_d;
    logic            ovf_q, ovf_d, udf_q, udf_d;
    logic            wr_en_s, rd_en_s, push_s, buf_nonempty_s, head_free_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == PW'(DEPTH - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    // Look-ahead full and accept qualification
    always_comb begin
        fifo_full      = (level_q == LW'(words)) && !shift_out;
        wr_en_s        = shift_in && !fifo_full;
        rd_en_s        = shift_out && head_vld_q;
        head_free_s    = !head_vld_q || rd_en_s;
        // Everything beyond the head sits in the buffer, so level minus head is the buffer count.
        buf_nonempty_s = level_q != {{(LW-1){1'b0}}, head_vld_q};
    end

    // Next-state: head refill/bypass, buffer push/pop, level and flags
    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        push_s     = 1'b0;
        level_d    = level_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        if (clear) begin
            head_d     = {bits{1'b0}};
            head_vld_d = 1'b0;
            rd_ptr_d   = {PW{1'b0}};
            wr_ptr_d   = {PW{1'b0}};
            level_d    = {LW{1'b0}};
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
        end else begin
            if (head_free_s) begin
                if (buf_nonempty_s) begin
                    head_d     = mem_q[rd_ptr_q];
                    head_vld_d = 1'b1;
                    rd_ptr_d   = ptr_inc(rd_ptr_q);
                    push_s     = wr_en_s;
                end else if (wr_en_s) begin
                    head_d     = data_in;
                    head_vld_d = 1'b1;
                end else begin
                    head_d     = {bits{1'b0}};
                    head_vld_d = 1'b0;
                end
            end else begin
                push_s = wr_en_s;
            end
            if (push_s) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            level_d = level_q + {{(LW-1){1'b0}}, wr_en_s} - {{(LW-1){1'b0}}, rd_en_s};
            ovf_d   = ovf_q | (shift_in && fifo_full);
            udf_d   = udf_q | (shift_out && !head_vld_q);
        end
        af_d = level_d >= LW'(af_level);
        ae_d = level_d <= LW'(ae_level);
    end

    // Control and head registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= {bits{1'b0}};
            head_vld_q <= 1'b0;
            rd_ptr_q   <= {PW{1'b0}};
            wr_ptr_q   <= {PW{1'b0}};
            level_q    <= {LW{1'b0}};
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            af_q       <= af_d;
            ae_q       <= ae_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Buffer storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push_s && !clear) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out          = head_q;
    assign fifo_not_empty    = head_vld_q;
    assign fifo_almost_full  = af_q;
    assign fifo_almost_empty = ae_q;
    assign level             = level_q;
    assign overflow          = ovf_q;
    assign underflow         = udf_q;
endmodule

// File: tb/tb_fifo_nword_fwft.sv
// Bench for fifo_nword_fwft: directed vector table, async-reset sequence and random
// traffic, all checked against a queue-based reference model.
module tb_fifo_nword_fwft;
    localparam int W  = 4;
    localparam int B  = 8;
    localparam int AF = 3;
    localparam int AE = 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0, shift_in = 1'b0, shift_out = 1'b0;
    logic [B-1:0] data_in = '0, data_out;
    logic         fifo_not_empty, fifo_full, fifo_almost_full, fifo_almost_empty;
    logic [2:0]   level;
    logic         overflow, underflow;

    fifo_nword_fwft #(.bits(B), .words(W), .af_level(AF), .ae_level(AE)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .shift_in(shift_in),
        .shift_out(shift_out), .data_in(data_in), .data_out(data_out),
        .fifo_not_empty(fifo_not_empty), .fifo_full(fifo_full),
        .fifo_almost_full(fifo_almost_full), .fifo_almost_empty(fifo_almost_empty),
        .level(level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [B-1:0] q[$];
    logic m_ovf = 1'b0, m_udf = 1'b0;

    typedef struct {
        logic si, so, clr;
        logic [B-1:0] din;
        int   lvl;
        logic ne;
        logic [B-1:0] dout;
        logic ovf, udf;
    } vec_t;
    vec_t tbl[26];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("level", 32'(level), 32'(q.size()));
        chk("not_empty", 32'(fifo_not_empty), 32'(q.size() > 0));
        chk("data_out", 32'(data_out), (q.size() > 0) ? 32'(q[0]) : 32'd0);
        chk("almost_full", 32'(fifo_almost_full), 32'(q.size() >= AF));
        chk("almost_empty", 32'(fifo_almost_empty), 32'(q.size() <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    // One clock of stimulus, checking look-ahead full before the edge and all outputs after it
    task automatic step(input logic si, input logic so, input logic clr, input logic [B-1:0] din);
        logic full, wr, rd;
        @(negedge clk);
        shift_in  = si;
        shift_out = so;
        clear     = clr;
        data_in   = din;
        #1;
        full = (q.size() == W) && !so;
        chk("fifo_full", 32'(fifo_full), 32'(full));
        wr = si && !full;
        rd = so && (q.size() > 0);
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else begin
            if (si && full) m_ovf = 1'b1;
            if (so && q.size() == 0) m_udf = 1'b1;
            if (rd) void'(q.pop_front());
            if (wr) q.push_back(din);
        end
        #1;
        chk_model();
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 8'h11, 1, 1, 8'h11, 0, 0};
        tbl[1]  = '{1, 0, 0, 8'h22, 2, 1, 8'h11, 0, 0};
        tbl[2]  = '{1, 0, 0, 8'h33, 3, 1, 8'h11, 0, 0};
        tbl[3]  = '{1, 0, 0, 8'h44, 4, 1, 8'h11, 0, 0};
        tbl[4]  = '{1, 0, 0, 8'h55, 4, 1, 8'h11, 1, 0};
        tbl[5]  = '{0, 1, 0, 8'h00, 3, 1, 8'h22, 1, 0};
        tbl[6]  = '{0, 1, 0, 8'h00, 2, 1, 8'h33, 1, 0};
        tbl[7]  = '{0, 1, 0, 8'h00, 1, 1, 8'h44, 1, 0};
        tbl[8]  = '{0, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0};
        tbl[9]  = '{0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0};
        tbl[10] = '{1, 0, 0, 8'h11, 1, 1, 8'h11, 0, 0};
        tbl[11] = '{1, 0, 0, 8'h22, 2, 1, 8'h11, 0, 0};
        tbl[12] = '{1, 0, 0, 8'h33, 3, 1, 8'h11, 0, 0};
        tbl[13] = '{1, 0, 0, 8'h44, 4, 1, 8'h11, 0, 0};
        tbl[14] = '{1, 1, 0, 8'h66, 4, 1, 8'h22, 0, 0};
        tbl[15] = '{1, 1, 0, 8'h67, 4, 1, 8'h33, 0, 0};
        tbl[16] = '{1, 1, 0, 8'h68, 4, 1, 8'h44, 0, 0};
        tbl[17] = '{1, 1, 0, 8'h69, 4, 1, 8'h66, 0, 0};
        tbl[18] = '{1, 1, 0, 8'h6A, 4, 1, 8'h67, 0, 0};
        tbl[19] = '{1, 1, 0, 8'h6B, 4, 1, 8'h68, 0, 0};
        tbl[20] = '{0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0};
        tbl[21] = '{1, 0, 0, 8'h77, 1, 1, 8'h77, 0, 0};
        tbl[22] = '{1, 1, 0, 8'h88, 1, 1, 8'h88, 0, 0};
        tbl[23] = '{0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
        tbl[24] = '{0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 1};
        tbl[25] = '{1, 0, 1, 8'h99, 0, 0, 8'h00, 0, 0};

        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_model();
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].si, tbl[i].so, tbl[i].clr, tbl[i].din);
            chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
            chk($sformatf("tbl%0d_ne", i), 32'(fifo_not_empty), 32'(tbl[i].ne));
            chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
            chk($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_udf", i), 32'(underflow), 32'(tbl[i].udf));
        end

        // Asynchronous reset in the middle of a cycle with three words held
        step(1'b1, 1'b0, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 1'b0, 8'hA2);
        step(1'b1, 1'b0, 1'b0, 8'hA3);
        chk("pre_reset_level", 32'(level), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_level", 32'(level), 32'd0);
        chk("async_rst_dout", 32'(data_out), 32'd0);
        chk("async_rst_ne", 32'(fifo_not_empty), 32'd0);
        chk("async_rst_ae", 32'(fifo_almost_empty), 32'd1);
        chk("async_rst_af", 32'(fifo_almost_full), 32'd0);
        shift_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'hAA);
        chk("post_reset_dout", 32'(data_out), 32'hAA);
        chk("post_reset_ne", 32'(fifo_not_empty), 32'd1);

        // Random traffic, with occasional flushes
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 3), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
